// File: rtl/tdm_mux_scan_if.sv
// Bus interface for tdm_mux_scan: channel inputs, mode controls and the
// tagged output sample. The optional parity signals exist only when
// TDM_MUX_SCAN_PARITY_EN is defined.
interface tdm_mux_scan_if #(
    parameter int N  = 16,
    parameter int W  = 1,
    parameter int SW = 4
);
    logic            en;
    logic            mode;
    logic [SW-1:0]   si;
    logic [N-1:0]    mask;
    logic [N*W-1:0]  di;
    logic [W-1:0]    y;
    logic [SW-1:0]   ch;
    logic            vld;
    logic            wrap;
`ifdef TDM_MUX_SCAN_PARITY_EN
    logic            par;
    logic [N-1:0]    pchk_i;

    modport master (output en, mode, si, mask, di, pchk_i,
                    input  y, ch, vld, wrap, par);
    modport slave  (input  en, mode, si, mask, di, pchk_i,
                    output y, ch, vld, wrap, par);
`else
    modport master (output en, mode, si, mask, di,
                    input  y, ch, vld, wrap);
    modport slave  (input  en, mode, si, mask, di,
                    output y, ch, vld, wrap);
`endif
endinterface

// File: rtl/tdm_mux_scan.sv
// tdm_mux_scan: registered N-channel, W-bit multiplexer with manual select
// and auto-scan (per-channel dwell, channel-enable mask, wrap pulse).
// Optional feature macro: TDM_MUX_SCAN_PARITY_EN adds a registered even
// parity output and per-channel expected parity that gates vld.
module tdm_mux_scan #(
    parameter int N     = 16,
    parameter int W     = 1,
    parameter int SW    = 4,
    parameter int DWELL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    tdm_mux_scan_if.slave   bus
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int NX = 2 ** SW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    y_q, y_d;
    logic [SW-1:0]   ch_q, ch_d;
    logic            vld_q, vld_d;
    logic            wrap_q, wrap_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            entry_q, entry_d;   // scan must restart at lowest channel

    logic [NX-1:0]   mask_ext_s;         // zero above N, so si>=N reads as masked
    logic            any_en_s;
    logic [SW-1:0]   low_s;
    logic [SW-1:0]   next_s;
    logic            has_next_s;
    logic            vld_ok_s;

    // Data of channel idx out of the packed input vector
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] d, input logic [SW-1:0] idx);
        logic [W-1:0] r;
        r = {W{1'b0}};
        for (int k = 0; k < N; k++) begin
            r = (SW'(k) == idx) ? d[k*W +: W] : r;
        end
        return r;
    endfunction

    // Lowest enabled channel index (0 when none is enabled)
    function automatic logic [SW-1:0] lowest(input logic [N-1:0] m);
        logic [SW-1:0] r;
        r = {SW{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            r = m[k] ? SW'(k) : r;
        end
        return r;
    endfunction

    // {found, index} of the nearest enabled channel strictly above cur
    function automatic logic [SW:0] next_above(input logic [N-1:0] m, input logic [SW-1:0] cur);
        logic [SW:0] r;
        r = {(SW+1){1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            r = (m[k] && (SW'(k) > cur)) ? {1'b1, SW'(k)} : r;
        end
        return r;
    endfunction

    // Channel search helpers derived from the current mask
    always_comb begin
        mask_ext_s               = NX'(bus.mask);
        any_en_s                 = |bus.mask;
        low_s                    = lowest(bus.mask);
        {has_next_s, next_s}     = next_above(bus.mask, ch_q);
    end

    // Next-state and output decode; the mode input decides this edge's action
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        ch_d    = ch_q;
        vld_d   = 1'b0;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        entry_d = entry_q;
        if (bus.en) begin
            state_d = bus.mode ? ST_SCAN : ST_MANUAL;
            if (!any_en_s) begin
                cnt_d   = {CW{1'b0}};
                entry_d = 1'b1;
            end else if (!bus.mode) begin
                if (mask_ext_s[bus.si]) begin
                    y_d   = pick(bus.di, bus.si);
                    ch_d  = bus.si;
                    vld_d = 1'b1;
                end else begin
                    ch_d  = ch_q;
                end
            end else if ((state_q != ST_SCAN) || entry_q) begin
                ch_d    = low_s;
                y_d     = pick(bus.di, low_s);
                vld_d   = 1'b1;
                cnt_d   = {CW{1'b0}};
                entry_d = 1'b0;
            end else if (!mask_ext_s[ch_q] || (cnt_q == CW'(DWELL - 1))) begin
                // dwell expired or current channel dropped out of the mask
                ch_d   = has_next_s ? next_s : low_s;
                wrap_d = !has_next_s;
                y_d    = pick(bus.di, has_next_s ? next_s : low_s);
                vld_d  = 1'b1;
                cnt_d  = {CW{1'b0}};
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end else begin
            state_d = state_q;
        end
    end

`ifdef TDM_MUX_SCAN_PARITY_EN
    logic            par_q, par_d;
    logic [NX-1:0]   pchk_ext_s;

    function automatic logic even_par(input logic [W-1:0] v);
        return ^v;
    endfunction

    // Parity of the value being loaded and its match against the channel's expectation
    always_comb begin
        pchk_ext_s = NX'(bus.pchk_i);
        par_d      = even_par(y_d);
        vld_ok_s   = (par_d == pchk_ext_s[ch_d]);
    end

    // Parity register, kept in step with y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign bus.par = par_q;
`else
    // Without parity every sample is accepted
    always_comb begin
        vld_ok_s = 1'b1;
    end
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= {W{1'b0}};
            ch_q    <= {SW{1'b0}};
            vld_q   <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            vld_q   <= vld_d & vld_ok_s;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            entry_q <= entry_d;
        end
    end

    assign bus.y    = y_q;
    assign bus.ch   = ch_q;
    assign bus.vld  = vld_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_tdm_mux_scan.sv
// Randomized self-checking bench for tdm_mux_scan: two instances
// (N=16/W=1/DWELL=3 and N=12/W=3/DWELL=2) against a list-based reference model.
module tb_tdm_mux_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        en_t   = 1'b0;
    logic        mode_t = 1'b0;
    logic [3:0]  si_t   = 4'd0;
    logic [15:0] mask_t = 16'h0000;
    logic [15:0] di0_t  = 16'h0000;
    logic [35:0] di1_t  = 36'h0;

    tdm_mux_scan_if #(.N(16), .W(1), .SW(4)) if0 ();
    tdm_mux_scan_if #(.N(12), .W(3), .SW(4)) if1 ();

    assign if0.en   = en_t;
    assign if0.mode = mode_t;
    assign if0.si   = si_t;
    assign if0.mask = mask_t;
    assign if0.di   = di0_t;
    assign if1.en   = en_t;
    assign if1.mode = mode_t;
    assign if1.si   = si_t;
    assign if1.mask = mask_t[11:0];
    assign if1.di   = di1_t;

    tdm_mux_scan #(.N(16), .W(1), .SW(4), .DWELL(3)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    tdm_mux_scan #(.N(12), .W(3), .SW(4), .DWELL(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int n_checks = 0;
    int n_errors = 0;

    // reference model state, one slot per instance
    int n_ch [2] = '{16, 12};
    int w_ch [2] = '{1, 3};
    int dw   [2] = '{3, 2};
    int m_y  [2];
    int m_ch [2];
    int m_cnt[2];
    bit m_scan [2];
    bit m_fresh[2];
    bit m_vld  [2];
    bit m_wrap [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_y[i] = 0; m_ch[i] = 0; m_cnt[i] = 0;
            m_scan[i] = 1'b0; m_fresh[i] = 1'b0; m_vld[i] = 1'b0; m_wrap[i] = 1'b0;
        end
    endtask

    task automatic model_sample(input int id, input int c, input logic [63:0] di);
        logic [63:0] t;
        t = di >> (c * w_ch[id]);
        m_y[id]  = int'(t[7:0]) & ((1 << w_ch[id]) - 1);
        m_ch[id] = c;
        m_vld[id] = 1'b1;
    endtask

    // One clock edge of behaviour, expressed over the list of enabled channels
    task automatic model_step(input int id, input bit en, input bit mode, input int si,
                              input logic [15:0] mask, input logic [63:0] di);
        int q[$];
        int nxt;
        m_vld[id]  = 1'b0;
        m_wrap[id] = 1'b0;
        if (!en) return;
        for (int k = 0; k < n_ch[id]; k++) if (mask[k]) q.push_back(k);
        if (q.size() == 0) begin
            m_cnt[id] = 0; m_fresh[id] = 1'b1; m_scan[id] = mode;
            return;
        end
        if (!mode) begin
            if (si < n_ch[id] && mask[si]) model_sample(id, si, di);
            m_scan[id] = 1'b0;
        end else begin
            if (!m_scan[id] || m_fresh[id]) begin
                model_sample(id, q[0], di);
                m_cnt[id] = 0; m_fresh[id] = 1'b0;
            end else if (!mask[m_ch[id]] || m_cnt[id] == dw[id] - 1) begin
                nxt = -1;
                foreach (q[i]) if (q[i] > m_ch[id] && nxt < 0) nxt = q[i];
                if (nxt < 0) begin
                    nxt = q[0];
                    m_wrap[id] = 1'b1;
                end
                model_sample(id, nxt, di);
                m_cnt[id] = 0;
            end else begin
                m_cnt[id]++;
            end
            m_scan[id] = 1'b1;
        end
    endtask

    task automatic compare_all();
        chk("y0",    32'(if0.y),    32'(m_y[0]));
        chk("ch0",   32'(if0.ch),   32'(m_ch[0]));
        chk("vld0",  32'(if0.vld),  32'(m_vld[0]));
        chk("wrap0", 32'(if0.wrap), 32'(m_wrap[0]));
        chk("y1",    32'(if1.y),    32'(m_y[1]));
        chk("ch1",   32'(if1.ch),   32'(m_ch[1]));
        chk("vld1",  32'(if1.vld),  32'(m_vld[1]));
        chk("wrap1", 32'(if1.wrap), 32'(m_wrap[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, en_t, mode_t, int'(si_t), mask_t, {48'h0, di0_t});
        model_step(1, en_t, mode_t, int'(si_t), {4'h0, mask_t[11:0]}, {28'h0, di1_t});
        #1;
        compare_all();
    endtask

    task automatic rand_di();
        di0_t = 16'($urandom);
        di1_t = {4'($urandom), 32'($urandom)};
    endtask

    // Reset pulse between clock edges; outputs must clear without an edge
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp_ch3[10] = '{0, 0, 0, 2, 2, 2, 5, 5, 5, 0};

    initial begin
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // manual walk over all channels
        en_t = 1'b1; mode_t = 1'b0; mask_t = 16'hFFFF;
        for (int s = 0; s < 16; s++) begin
            si_t = 4'(s);
            di0_t = 16'h0001 << s;
            di1_t = {4'($urandom), 32'($urandom)};
            tick();
            chk("t1_y", 32'(if0.y), 32'd1);
            chk("t1_ch", 32'(if0.ch), 32'(s));
            chk("t1_vld", 32'(if0.vld), 32'd1);
        end

        // masked and out-of-range selects hold
        mask_t = 16'h00FF; si_t = 4'd9;
        for (int i = 0; i < 2; i++) begin
            rand_di(); tick();
            chk("t2_vld", 32'(if0.vld), 32'd0);
        end
        mask_t = 16'hFFFF; si_t = 4'd13;
        rand_di(); tick();
        chk("t2_oor_vld", 32'(if1.vld), 32'd0);

        // scan with skipped channels
        mode_t = 1'b1; mask_t = 16'h0025;
        for (int i = 0; i < 10; i++) begin
            rand_di(); tick();
            chk("t3_ch", 32'(if0.ch), 32'(exp_ch3[i]));
            chk("t3_vld", 32'(if0.vld), 32'((i % 3) == 0));
            chk("t3_wrap", 32'(if0.wrap), 32'(i == 9));
        end

        // freeze, then empty mask, then a single channel returns
        en_t = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_di(); tick();
            chk("t4_frz_vld", 32'(if0.vld), 32'd0);
        end
        en_t = 1'b1; mask_t = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            rand_di(); tick();
            chk("t4_zero_vld", 32'(if0.vld), 32'd0);
        end
        mask_t = 16'h0010;
        rand_di(); tick();
        chk("t4_ch", 32'(if0.ch), 32'd4);
        chk("t4_vld", 32'(if0.vld), 32'd1);

        // async reset mid-scan
        mask_t = 16'h0025;
        for (int i = 0; i < 4; i++) begin rand_di(); tick(); end
        async_reset();
        mask_t = 16'h0024;
        rand_di(); tick();
        chk("t5_ch", 32'(if0.ch), 32'd2);
        chk("t5_vld", 32'(if0.vld), 32'd1);

        // mode switch from channel 5 and back
        mask_t = 16'h0025;
        for (int i = 0; i < 20 && m_ch[0] != 5; i++) begin rand_di(); tick(); end
        chk("t6_reach", 32'(if0.ch), 32'd5);
        mode_t = 1'b0; si_t = 4'd3; mask_t = 16'h002D;
        rand_di(); tick();
        chk("t6_man_ch", 32'(if0.ch), 32'd3);
        chk("t6_man_vld", 32'(if0.vld), 32'd1);
        mode_t = 1'b1;
        rand_di(); tick();
        chk("t6_scan_ch", 32'(if0.ch), 32'd0);
        for (int i = 0; i < 3; i++) begin rand_di(); tick(); end
        chk("t6_dwell_ch", 32'(if0.ch), 32'd2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            en_t = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode_t = ~mode_t;
            si_t = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 3))
                    0:       mask_t = 16'h0000;
                    1:       mask_t = 16'h0001 << $urandom_range(0, 15);
                    2:       mask_t = 16'($urandom) & 16'($urandom);
                    default: mask_t = 16'($urandom);
                endcase
            end
            rand_di();
            tick();
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tdm_mux_scan.md
Name: tdm_mux_scan

Overview:
- Parametrised, registered N-channel W-bit multiplexer; successor to the fixed 16x1 gate-level mux.
- Adds two modes: manual select, and auto-scan with a per-channel dwell time.
- A channel-enable mask lets scan mode skip unused channels.
- Sits between multi-channel sample sources and a single serial/processing path; output comes with channel tag and valid pulse.

Parameters:
N, 16, number of input channels (2..64)
W, 1, data width per channel in bits
SW, 4, select/tag width; must satisfy 2**SW >= N
DWELL, 1, cycles spent on each channel in scan mode (1..256)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; low freezes all state
mode  input  1  0 = manual select, 1 = auto-scan
si  input  SW  manual channel select
mask  input  N  channel enable, bit k enables channel k
di  input  N*W  packed channel data; channel k = di[k*W +: W]
y  output  W  registered selected data
ch  output  SW  channel index that y was sampled from
vld  output  1  one-cycle pulse: y/ch updated with a new valid sample
wrap  output  1  one-cycle pulse: scan advanced from highest to lowest enabled channel

Behaviour:
- Reset (async assert, sync release): y=0, ch=0, vld=0, wrap=0, dwell counter=0, state=IDLE.
- States:
  - IDLE: entered after reset. Next cycle with en=1 goes to MANUAL (mode=0) or SCAN (mode=1).
  - MANUAL: mode=1 with en=1 goes to SCAN.
  - SCAN: mode=0 with en=1 goes to MANUAL.
  - The mode change takes effect on that same edge.
- en=0, any state: y, ch, state and dwell counter hold; vld=0; wrap=0.
- MANUAL, each en=1 cycle:
  - If si<N and mask[si]=1: y<=di[si], ch<=si, vld<=1. Latency is 1 clock from si/di to y.
  - Otherwise (si>=N or channel masked): y and ch hold, vld<=0.
- SCAN entry: from IDLE or MANUAL, on the same edge, select the lowest enabled channel; sample y<=di[that], ch<=index, vld<=1; dwell counter<=0.
- SCAN running:
  - Dwell counter increments each en=1 cycle.
  - When it reaches DWELL-1, the next edge advances to the next higher enabled channel, samples it, pulses vld, and clears the counter.
  - y is sampled once per dwell, at channel entry, and held for the dwell.
  - DWELL=1 gives a new channel every cycle.
- Wrap-around: if no higher enabled channel exists, advance to the lowest enabled channel and pulse wrap together with vld.
  - Single enabled channel: re-sample it every DWELL cycles, with wrap=1 each time.
- mask=0 (all zero), any mode: vld=0, wrap=0, y and ch hold, counter held at 0.
  - When any bit becomes 1 in SCAN, the next edge treats it as scan entry.
- Current channel masked mid-dwell in SCAN: the next edge advances immediately, as if the dwell had expired.
- Reset asserted mid-operation: outputs clear immediately, without waiting for a clock edge.

Optional Feature:
- Macro TDM_MUX_SCAN_PARITY_EN.
- When defined:
  - Adds output port par (1 bit): even parity of the y value being loaded, registered together with y; par=0 after reset.
  - Adds input pchk_i (N bits): expected parity per channel.
  - vld is suppressed for a sample whose computed parity differs from pchk_i[ch]. In that case y still updates.
- When undefined: neither port exists and behaviour is exactly as above.

Test Plan:
1. Reset then manual mode: N=16, W=1, mask=16'hFFFF, walk si 0..15 with di=1<<si. Required: y=1 and vld=1 one cycle after each select, ch=si.
2. Manual masked or out-of-range select: mask=16'h00FF, si=9. Required: vld=0 and y/ch hold their previous value. Then N=12, si=13: same hold.
3. Scan with skip: DWELL=3, mask=16'h0025. Required: ch sequence 0,2,5,0, with each channel held 3 cycles and vld every 3rd cycle. wrap=1 only on the 5->0 transition.
4. Freeze and mask clear: scan running, en=0 for 5 cycles. Required: ch/y/counter frozen, vld=0. Then mask=0: vld stays 0. Then mask=16'h0010: ch=4 with vld on the next edge.
5. Async reset mid-scan: assert rst_n low between clock edges. Required: y=0, ch=0, vld=0 without a clock. After release with mode=1: IDLE, then scan entry at the lowest enabled channel.
6. Mode switch: in SCAN at ch=5, set mode=0 with si=3. Required: next edge ch=3, vld=1. Switching back to mode=1: ch = lowest enabled channel, dwell counter restarted.
